// File: rtl/dff_pipe_pkg.sv
// Shared types and helpers for the dff_pipe delay line.
package dff_pipe_pkg;

    // Capture edge used by every register in the pipe.
    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } edge_e;

    // Width of a counter that must hold values 0..depth.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One {valid, data} register with stall, flush and async reset on a selectable edge.
module dff_stage
    import dff_pipe_pkg::*;
#(
    parameter int    WIDTH = 8,
    parameter edge_e EDGE  = EDGE_RISE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] d,
    output logic             vld_out,
    output logic [WIDTH-1:0] q
);

    logic             vld_q;
    logic             vld_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state: flush beats shift, otherwise hold.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clr) begin
            vld_d  = 1'b0;
            data_d = '0;
        end else if (en) begin
            vld_d  = vld_in;
            data_d = d;
        end
    end

    // Edge chosen structurally so the clock net itself is never inverted.
    generate
        if (EDGE == EDGE_FALL) begin : g_fall
            // Stage register, captures on the falling edge.
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q  <= 1'b0;
                    data_q <= '0;
                end else begin
                    vld_q  <= vld_d;
                    data_q <= data_d;
                end
            end
        end else begin : g_rise
            // Stage register, captures on the rising edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q  <= 1'b0;
                    data_q <= '0;
                end else begin
                    vld_q  <= vld_d;
                    data_q <= data_d;
                end
            end
        end
    endgenerate

    assign vld_out = vld_q;
    assign q       = data_q;

endmodule

// File: rtl/dff_pipe.sv
// Fixed-latency stallable delay line with valid tracking and live occupancy count.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int    WIDTH = 8,
    parameter int    DEPTH = 3,
    parameter edge_e EDGE  = EDGE_RISE,
    parameter int    CW    = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             vld_out,
    output logic [CW-1:0]    occ
);

    logic [DEPTH:0]   vld_chain;
    logic [WIDTH-1:0] data_chain [DEPTH+1];
    logic [CW-1:0]    occ_q;
    logic [CW-1:0]    occ_d;

    assign vld_chain[0]  = vld_in;
    assign data_chain[0] = d;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            dff_stage #(
                .WIDTH (WIDTH),
                .EDGE  (EDGE)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en),
                .clr     (clr),
                .vld_in  (vld_chain[i]),
                .d       (data_chain[i]),
                .vld_out (vld_chain[i+1]),
                .q       (data_chain[i+1])
            );
        end
    endgenerate

    assign q       = data_chain[DEPTH];
    assign vld_out = vld_chain[DEPTH];

    // Occupancy tracks entering minus leaving valids; modular arithmetic
    // cancels any intermediate wrap since the true result stays in 0..DEPTH.
    always_comb begin
        occ_d = occ_q;
        if (clr) begin
            occ_d = '0;
        end else if (en) begin
            occ_d = occ_q + CW'(vld_in) - CW'(vld_out);
        end
    end

    generate
        if (EDGE == EDGE_FALL) begin : g_occ_fall
            // Occupancy register on the falling edge, in step with the stages.
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) occ_q <= '0;
                else        occ_q <= occ_d;
            end
        end else begin : g_occ_rise
            // Occupancy register on the rising edge, in step with the stages.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) occ_q <= '0;
                else        occ_q <= occ_d;
            end
        end
    endgenerate

    assign occ = occ_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: rising-edge DEPTH=3, falling-edge DEPTH=1, random DEPTH=5.
module tb_dff_pipe;
    import dff_pipe_pkg::*;

    logic clk;
    logic rst_n;

    // Rising-edge, DEPTH=3 instance
    logic       en_r, clr_r, vin_r;
    logic [7:0] d_r, q_r;
    logic       vo_r;
    logic [1:0] occ_r;

    // Falling-edge, DEPTH=1 instance
    logic       en_f, clr_f, vin_f;
    logic [7:0] d_f, q_f;
    logic       vo_f;
    logic [0:0] occ_f;

    // Rising-edge, DEPTH=5 instance for random traffic
    logic       en_x, clr_x, vin_x;
    logic [7:0] d_x, q_x;
    logic       vo_x;
    logic [2:0] occ_x;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];

    dff_pipe #(.WIDTH(8), .DEPTH(3), .EDGE(EDGE_RISE)) u_rise (
        .clk(clk), .rst_n(rst_n), .en(en_r), .clr(clr_r), .vld_in(vin_r),
        .d(d_r), .q(q_r), .vld_out(vo_r), .occ(occ_r)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(1), .EDGE(EDGE_FALL)) u_fall (
        .clk(clk), .rst_n(rst_n), .en(en_f), .clr(clr_f), .vld_in(vin_f),
        .d(d_f), .q(q_f), .vld_out(vo_f), .occ(occ_f)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(5), .EDGE(EDGE_RISE)) u_rand (
        .clk(clk), .rst_n(rst_n), .en(en_x), .clr(clr_x), .vld_in(vin_x),
        .d(d_x), .q(q_x), .vld_out(vo_x), .occ(occ_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive the rise instance for one edge; valid items are pushed to the scoreboard.
    task automatic step_r(input logic en, input logic clr, input logic v, input logic [7:0] dv);
        en_r  = en;
        clr_r = clr;
        vin_r = v;
        d_r   = dv;
        if (en && !clr && v) exp_q.push_back(dv);
        @(posedge clk);
        #1;
        if (clr) exp_q.delete();
    endtask

    // Monitor: inputs are stable between negedge and the next posedge, so an item
    // that will leave the last stage at that posedge is compared here.
    always @(negedge clk) begin
        if (rst_n && en_r && !clr_r && vo_r) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_underflow: q=%0h with nothing expected", q_r);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                if (q_r !== e) begin
                    fails++;
                    $display("FAIL sb_data: got %0h expected %0h at %0t", q_r, e, $time);
                end
            end
        end
    end

    logic       mv [5];
    logic [7:0] md [5];

    initial begin
        rst_n = 1'b0;
        en_r = 0; clr_r = 0; vin_r = 0; d_r = '0;
        en_f = 0; clr_f = 0; vin_f = 0; d_f = '0;
        en_x = 0; clr_x = 0; vin_x = 0; d_x = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q_r",   32'(q_r),   32'h0);
        chk("rst_vo_r",  32'(vo_r),  32'h0);
        chk("rst_occ_r", 32'(occ_r), 32'h0);
        chk("rst_q_f",   32'(q_f),   32'h0);
        chk("rst_occ_x", 32'(occ_x), 32'h0);
        rst_n = 1'b1;

        // Reset mid-stream
        step_r(1, 0, 1, 8'h11);
        step_r(1, 0, 1, 8'h22);
        step_r(1, 0, 1, 8'h33);
        chk("mid_pre_vo",  32'(vo_r),  32'h1);
        chk("mid_pre_occ", 32'(occ_r), 32'h3);
        #2;
        rst_n = 1'b0;
        en_r  = 1'b0;
        #1;
        chk("mid_rst_q",   32'(q_r),   32'h0);
        chk("mid_rst_vo",  32'(vo_r),  32'h0);
        chk("mid_rst_occ", 32'(occ_r), 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Latency and fill
        step_r(1, 0, 1, 8'hA1);
        chk("fill1_occ", 32'(occ_r), 32'h1); chk("fill1_vo", 32'(vo_r), 32'h0);
        step_r(1, 0, 1, 8'hA2);
        chk("fill2_occ", 32'(occ_r), 32'h2); chk("fill2_vo", 32'(vo_r), 32'h0);
        step_r(1, 0, 1, 8'hA3);
        chk("fill3_occ", 32'(occ_r), 32'h3); chk("fill3_vo", 32'(vo_r), 32'h1);
        chk("fill3_q", 32'(q_r), 32'hA1);
        step_r(1, 0, 1, 8'hA4);
        chk("fill4_occ", 32'(occ_r), 32'h3); chk("fill4_q", 32'(q_r), 32'hA2);

        // Stall with toggling data
        for (int unsigned i = 0; i < 4; i++) begin
            step_r(0, 0, 1, (i % 2 == 0) ? 8'h55 : 8'hAA);
            chk("stall_q",   32'(q_r),   32'hA2);
            chk("stall_occ", 32'(occ_r), 32'h3);
            chk("stall_vo",  32'(vo_r),  32'h1);
        end
        step_r(1, 0, 0, 8'h00);
        chk("resume_q", 32'(q_r), 32'hA3); chk("resume_occ", 32'(occ_r), 32'h2);
        step_r(1, 0, 0, 8'h00);
        chk("drain1_q", 32'(q_r), 32'hA4); chk("drain1_occ", 32'(occ_r), 32'h1);
        step_r(1, 0, 0, 8'h00);
        chk("drain2_vo", 32'(vo_r), 32'h0); chk("drain2_occ", 32'(occ_r), 32'h0);

        // Bubbles then flush
        step_r(1, 0, 1, 8'h5A);
        chk("bub1_occ", 32'(occ_r), 32'h1);
        step_r(1, 0, 0, 8'hFF);
        chk("bub2_occ", 32'(occ_r), 32'h1);
        step_r(1, 0, 1, 8'hC3);
        chk("bub3_occ", 32'(occ_r), 32'h2); chk("bub3_vo", 32'(vo_r), 32'h1);
        chk("bub3_q", 32'(q_r), 32'h5A);
        step_r(1, 0, 0, 8'h00);
        chk("bub4_occ", 32'(occ_r), 32'h1); chk("bub4_vo", 32'(vo_r), 32'h0);
        chk("bub4_q", 32'(q_r), 32'hFF);
        step_r(1, 0, 0, 8'h00);
        chk("bub5_occ", 32'(occ_r), 32'h1); chk("bub5_vo", 32'(vo_r), 32'h1);
        chk("bub5_q", 32'(q_r), 32'hC3);
        step_r(1, 1, 1, 8'h77);
        chk("flush_vo", 32'(vo_r), 32'h0); chk("flush_q", 32'(q_r), 32'h0);
        chk("flush_occ", 32'(occ_r), 32'h0);
        en_r = 0; clr_r = 0; vin_r = 0;

        // Falling-edge DEPTH=1: clk is high here
        en_f = 1; vin_f = 1; d_f = 8'h3C;
        @(negedge clk);
        #1;
        chk("fall_q", 32'(q_f), 32'h3C); chk("fall_vo", 32'(vo_f), 32'h1);
        chk("fall_occ", 32'(occ_f), 32'h1);
        d_f = 8'h55;
        @(posedge clk);
        #1;
        chk("fall_pos_hold", 32'(q_f), 32'h3C);
        @(negedge clk);
        #1;
        chk("fall_q2", 32'(q_f), 32'h55);
        @(posedge clk);
        #1;
        vin_f = 0; d_f = 8'h00;
        @(negedge clk);
        #1;
        chk("fall_empty_vo", 32'(vo_f), 32'h0); chk("fall_empty_occ", 32'(occ_f), 32'h0);
        en_f = 0;
        @(posedge clk);
        #1;

        // Random traffic on DEPTH=5 against a shift-register reference
        for (int unsigned n = 0; n < 1000; n++) begin
            automatic int unsigned pc = 0;
            en_x  = ($urandom_range(0, 3) != 0);
            clr_x = ($urandom_range(0, 19) == 0);
            vin_x = 1'($urandom_range(0, 1));
            d_x   = 8'($urandom);
            @(posedge clk);
            if (clr_x) begin
                for (int unsigned i = 0; i < 5; i++) begin
                    mv[i] = 1'b0;
                    md[i] = '0;
                end
            end else if (en_x) begin
                for (int unsigned i = 4; i > 0; i--) begin
                    mv[i] = mv[i-1];
                    md[i] = md[i-1];
                end
                mv[0] = vin_x;
                md[0] = d_x;
            end
            for (int unsigned i = 0; i < 5; i++) pc += 32'(mv[i]);
            #1;
            chk("rand_occ", 32'(occ_x), pc);
            chk("rand_vo",  32'(vo_x),  32'(mv[4]));
            chk("rand_q",   32'(q_x),   32'(md[4]));
            chk("rand_occ_max", 32'(occ_x <= 3'd5), 32'h1);
        end
        en_x = 0; clr_x = 0; vin_x = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised successor to the single-bit posedge/negedge flip-flop primitives.
- WIDTH-bit data plus a valid bit, delayed through DEPTH register stages.
- The capture edge is selectable by parameter.
- Adds a global enable (stall), a synchronous flush, asynchronous active-low reset, and a live occupancy count.
- Used wherever the design needs a fixed-latency, stallable delay line with valid tracking.

Parameters:
- WIDTH, 8, data width in bits; legal range ≥1.
- DEPTH, 3, number of register stages, which is also the latency; legal range ≥1.
- EDGE, EDGE_RISE, capture edge of every stage.
  - EDGE_RISE: stages capture on posedge clk.
  - EDGE_FALL: stages capture on negedge clk.
- CW, $clog2(DEPTH+1), occupancy counter width. Derived; do not override.

Ports:
- clk  input  1  single clock. Only the edge selected by EDGE is used.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  shift enable. 0 = every stage holds.
- clr  input  1  synchronous flush. Has priority over en.
- vld_in  input  1  qualifies d.
- d  input  WIDTH  input data.
- q  output  WIDTH  data from the last stage.
- vld_out  output  1  valid bit from the last stage.
- occ  output  CW  number of stages currently holding valid=1.

Behaviour:
- Reset (rst_n=0): takes effect immediately, asynchronously, independent of EDGE.
  - All stage data, all valid bits, and occ are cleared to 0.
  - Outputs are therefore q=0, vld_out=0, occ=0.
  - Deassertion is sampled at the next active edge; the first capture happens on that edge.
- Active edge = posedge clk when EDGE=EDGE_RISE, negedge clk when EDGE=EDGE_FALL. No logic is clocked on the other edge.
- Stage update, in priority order at each active edge:
  1. clr=1: every stage's data is set to 0 and valid to 0; occ is set to 0. en is ignored.
  2. en=1:
     - stage[0] ← {vld_in, d}.
     - stage[i] ← stage[i-1] for i = 1..DEPTH-1.
     - occ ← occ + vld_in − vld_out, where vld_out is the pre-edge value.
  3. Otherwise: every stage and occ hold.
- Data is captured regardless of vld_in. Invalid stages may carry non-zero data; consumers must qualify q with vld_out.
- Latency: a sample presented before active edge k appears on q/vld_out after edge k+DEPTH−1. That is DEPTH edges with en=1; edges with en=0 do not count.
- q, vld_out and occ are registered. No combinational path from any input to any output.
- occ invariant: occ always equals the popcount of the stage valid bits. Range is 0..DEPTH, no wrap.
  - Full (occ=DEPTH) with vld_in=1 and en=1: occ stays DEPTH because vld_out leaves as vld_in enters.
  - Empty (occ=0) with vld_in=0: occ stays 0.
- Simultaneous events:
  - clr and en both high: clr wins.
  - rst_n low together with anything: reset wins.
- DEPTH=1: single register; occ is 1 bit.
- Inputs must be stable around the selected active edge only.

Decomposition:
- Package dff_pipe_pkg:
  - typedef enum logic {EDGE_RISE=1'b0, EDGE_FALL=1'b1} edge_e.
  - Function occ_width(depth) returning $clog2(depth+1).
- Sub-module dff_stage:
  - One {valid, WIDTH data} register with en, clr, async rst_n, and the EDGE parameter.
  - Edge selection is done with a generate branch: posedge vs negedge always_ff. Clock inversion is forbidden.
- dff_pipe instantiates DEPTH dff_stage instances in a generate loop and holds the occ counter.
- The occ counter is clocked on the same edge via the same generate selection.

Test Plan:
- All scenarios use WIDTH=8 and DEPTH=3 unless stated.
- Reset mid-stream: with EDGE=EDGE_RISE, feed 0x11, 0x22, 0x33 valid, then drop rst_n between edges → q=0, vld_out=0, occ=0 immediately, before the next clock edge.
- Latency and fill, EDGE=EDGE_RISE, en=1: drive vld_in=1 with d=0xA1 at edge 1, 0xA2 at edge 2, 0xA3 at edge 3, 0xA4 at edge 4.
  - vld_out goes 1 after edge 3 with q=0xA1, then 0xA2 after edge 4.
  - occ steps 1, 2, 3, 3.
- Stall: from full (0xA2, 0xA3, 0xA4), hold en=0 for 4 edges while d toggles → q stays 0xA2 and occ stays 3. Reassert en → 0xA3 appears after the next edge.
- Bubbles and flush: pattern vld_in = 1, 0, 1 with d = 0x5A, 0xFF, 0xC3 → vld_out sequence 1, 0, 1 and occ peaks at 2. Then clr=1 together with en=1 and vld_in=1 → after the edge, vld_out=0, q=0, occ=0.
- Falling edge, EDGE=EDGE_FALL, DEPTH=1: change d only while clk is high, with d=0x3C stable before the negedge → q=0x3C updates at the negedge. A posedge with a different d produces no change.
- Occupancy invariant: random en/clr/vld_in for 1000 edges with DEPTH=5 → occ equals popcount(stage valids) every cycle, never exceeds 5, and q matches a reference queue model.
